ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Parametrised successor to the single-slot PS/2 scan-code state block. Consumes raw set-2 scan-code bytes from the PS/2 receiver, tracks E0/F0 prefixes, the E1 Pause sequence and Caps/Num/Scroll lock state, and emits structured key events through a `FIFO_DEPTH`-entry queue to the terminal input path. Command responses (ACK, RESEND, self-test) raise registered one-cycle strobes for the PS/2 command sequencer.

## Interface
- `FIFO_DEPTH`, 4, event queue depth; power of two, at least 2.
- `clk`  in  1  system clock.
- `reset_low`  in  1  asynchronous, active-low reset.
- `scan_code_valid`  in  1  receiver holds a byte.
- `scan_code_byte`  in  8  received byte.
- `scan_code_ready`  out  1  byte accepted when valid and ready are both high; equals queue not full.
- `event_valid`  out  1  queue not empty.
- `event_ready`  in  1  consumer takes the head event.
- `event_code`  out  8  key code at the queue head.
- `event_extended`  out  1  head event was E0-prefixed.
- `event_released`  out  1  head event is a release; constant 0 unless `PS2_KEY_RELEASE_EN` is defined.
- `acknowledge`, `resend`  out  1  one-cycle strobes.
- `set_status`  out  1  one-cycle strobe: the lock LEDs must be rewritten.
- `status_caps_lock`, `status_num_lock`, `status_scroll_lock`  out  1  registered lock state.

## Operation
- Accept = `scan_code_valid && scan_code_ready`. All state updates occur only on accept or on dequeue.
- Prefix flags `extended` and `released` are set by E0 and F0. F0 keeps `extended`. Any other accepted byte clears both after use.
- Pause swallow counter, 3 bits:
  - E1 with the counter at 0 enqueues press event {code E1, ext 0, rel 0} and loads the counter with 7.
  - While the counter is nonzero, every accepted byte is dropped (including FA/FE/AA) and the counter decrements.
- Byte classes apply only when the counter is 0 and `extended` = 0:
  - FA: `acknowledge`.
  - FE: `resend`.
  - AA: `set_status`, and both prefix flags clear.
  - None of these three is enqueued.
- Lock keys are 58 (caps), 77 (num) and 7E (scroll), without E0.
  - Press toggles the matching lock bit, raises `set_status` and enqueues the event.
  - Release does not toggle.
- Every other code: a press is enqueued with {code, extended, 0}. A release is enqueued or dropped according to the Configuration section.
- Dequeue = `event_valid && event_ready`. Enqueue and dequeue in the same cycle leave the count unchanged.
- Reset:
  - Queue empty, so `event_valid` = 0 and `scan_code_ready` = 1.
  - Prefix flags, counter, lock bits and all strobes = 0.
  - `event_code` = 00, `event_extended` = 0, `event_released` = 0.
  - Asserting reset mid-Pause or mid-prefix discards the partial sequence.

## Timing
- `scan_code_ready` is combinational from the queue count, with no dependency on `scan_code_valid`.
- An event accepted at edge N is visible on `event_*` after edge N if the queue was empty: one-cycle latency.
- Head outputs come from registered storage and stay stable while `event_valid && !event_ready`.
- Strobes are registered and high for exactly the one cycle after the accepting edge.
- Lock outputs carry the new value in the same cycle as `set_status`.
- When the queue is full, `scan_code_ready` = 0. Prefix, AA and FA bytes then also stall, which keeps all state in byte order.
- Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. The count is one bit wider.

## Configuration
- `PS2_KEY_RELEASE_EN` defined: releases are enqueued as {code, extended, 1}. Pause produces only its press event.
- Undefined: releases are dropped without a queue write. `event_released` is tied to 0 and its storage bit is removed.

## Structure
- `ps2_pkg` holds the scan-code constants (AA, E0, E1, F0, FA, FE, 58, 77, 7E) and the `ps2_key_event_t` packed struct {released, extended, code[7:0]}.
- Sub-module `ps2_event_fifo`, parametrised by depth and element type, implements the synchronous queue with valid/ready on both sides.

## Test plan
- Bytes 1C, then E0 75, with the consumer always ready: events {1C,0,0} then {75,1,0}; `scan_code_ready` never drops.
- Bytes 58, then F0 58: caps goes to 1 with a `set_status` pulse one cycle after the 58; event {58,0,0}; the release does not toggle. With the macro, a second event {58,0,1} follows.
- Bytes E1 14 77 E1 F0 14 F0 77: exactly one event {E1,0,0}; no lock toggle; the counter returns to 0. Then 77 toggles num to 1.
- Consumer stalled, bytes 1C 1B 23 2B 34 with depth 4: `scan_code_ready` goes low after the 4th; the 5th waits. One dequeue accepts it; the output order is preserved.
- Bytes FA, FE, AA: `acknowledge`, `resend` and `set_status` each pulse once; no events.
- `reset_low` pulsed after E0 F0 and after E1 14: the next byte 1C yields {1C,0,0}; locks are 0; the queue is empty.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Set-2 scan-code constants and key-event types shared by the
//               PS/2 key decoder and its event queue.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Scan-code bytes with special meaning to the decoder
    localparam logic [7:0] c_SC_AA = 8'hAA;  // keyboard self-test passed
    localparam logic [7:0] c_SC_E0 = 8'hE0;  // extended-key prefix
    localparam logic [7:0] c_SC_E1 = 8'hE1;  // Pause sequence start
    localparam logic [7:0] c_SC_F0 = 8'hF0;  // break (release) prefix
    localparam logic [7:0] c_SC_FA = 8'hFA;  // command acknowledge
    localparam logic [7:0] c_SC_FE = 8'hFE;  // command resend request
    localparam logic [7:0] c_SC_58 = 8'h58;  // Caps Lock
    localparam logic [7:0] c_SC_77 = 8'h77;  // Num Lock
    localparam logic [7:0] c_SC_7E = 8'h7E;  // Scroll Lock

    // Bytes swallowed after E1 (E1 14 77 E1 F0 14 F0 77 is 8 bytes total)
    localparam logic [2:0] c_PAUSE_SWALLOW = 3'd7;

    // Full key event, used when releases are reported
    typedef struct packed {
        logic       released;
        logic       extended;
        logic [7:0] code;
    } ps2_key_event_t;

    // Press-only key event: the released bit has no storage
    typedef struct packed {
        logic       extended;
        logic [7:0] code;
    } ps2_key_event_nr_t;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_event_fifo
// Description : Synchronous valid/ready queue of DEPTH entries of element
//               type T. DEPTH must be a power of two and at least 2 so the
//               pointers wrap naturally. The head entry is read straight from
//               register storage, so it is stable while the consumer stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_event_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    T                   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign in_ready  = (r_count != c_FULL);
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    // Storage, pointers and occupancy; a simultaneous push and pop nets zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : ps2_event_fifo
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : Set-2 scan-code decoder. Tracks E0/F0 prefixes, swallows the
//               E1 Pause sequence, maintains Caps/Num/Scroll lock state and
//               queues key events for the terminal input path. Keyboard
//               command responses (FA, FE, AA) become one-cycle strobes.
// Options     : PS2_KEY_RELEASE_EN - when defined, key releases are queued
//               with released = 1; otherwise they are dropped and the
//               released bit has no storage.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_low,
    input  logic       scan_code_valid,
    input  logic [7:0] scan_code_byte,
    output logic       scan_code_ready,
    output logic       event_valid,
    input  logic       event_ready,
    output logic [7:0] event_code,
    output logic       event_extended,
    output logic       event_released,
    output logic       acknowledge,
    output logic       resend,
    output logic       set_status,
    output logic       status_caps_lock,
    output logic       status_num_lock,
    output logic       status_scroll_lock
);

`ifdef PS2_KEY_RELEASE_EN
    typedef ps2_key_event_t    evt_t;
`else
    typedef ps2_key_event_nr_t evt_t;
`endif

    // Decoder state
    logic       r_extended;
    logic       r_released;
    logic [2:0] r_pause_cnt;

    // Next-state / enqueue decisions for the byte being accepted
    logic       w_accept;
    logic       w_push;
    evt_t       w_evt;
    evt_t       w_head;
    logic       w_extended_nxt;
    logic       w_released_nxt;
    logic [2:0] w_pause_cnt_nxt;
    logic       w_ack_nxt;
    logic       w_resend_nxt;
    logic       w_status_nxt;
    logic       w_caps_nxt;
    logic       w_num_nxt;
    logic       w_scroll_nxt;
    logic       w_fifo_in_ready;

    // Every byte class stalls together on a full queue, so bytes are always
    // processed in order even when they would not themselves be enqueued.
    assign w_accept        = scan_code_valid && w_fifo_in_ready;
    assign scan_code_ready = w_fifo_in_ready;

    // Classify the accepted byte and decide what it does to the state
    always_comb begin
        w_push          = 1'b0;
        w_evt           = '0;
        w_evt.code      = scan_code_byte;
        w_evt.extended  = r_extended;
        w_extended_nxt  = r_extended;
        w_released_nxt  = r_released;
        w_pause_cnt_nxt = r_pause_cnt;
        w_ack_nxt       = 1'b0;
        w_resend_nxt    = 1'b0;
        w_status_nxt    = 1'b0;
        w_caps_nxt      = status_caps_lock;
        w_num_nxt       = status_num_lock;
        w_scroll_nxt    = status_scroll_lock;

        if (w_accept) begin
            if (r_pause_cnt != 3'd0) begin
                // Tail of the Pause sequence, including any FA/FE/AA inside it
                w_pause_cnt_nxt = r_pause_cnt - 3'd1;
            end else if (scan_code_byte == c_SC_E1) begin
                w_push          = 1'b1;
                w_evt.code      = c_SC_E1;
                w_evt.extended  = 1'b0;
                w_pause_cnt_nxt = c_PAUSE_SWALLOW;
                w_extended_nxt  = 1'b0;
                w_released_nxt  = 1'b0;
            end else if (scan_code_byte == c_SC_E0) begin
                w_extended_nxt = 1'b1;
            end else if (scan_code_byte == c_SC_F0) begin
                // F0 leaves a pending E0 in place (E0 F0 xx)
                w_released_nxt = 1'b1;
            end else if (!r_extended && scan_code_byte == c_SC_FA) begin
                w_ack_nxt      = 1'b1;
                w_released_nxt = 1'b0;
            end else if (!r_extended && scan_code_byte == c_SC_FE) begin
                w_resend_nxt   = 1'b1;
                w_released_nxt = 1'b0;
            end else if (!r_extended && scan_code_byte == c_SC_AA) begin
                // Keyboard reset itself: LEDs must be rewritten
                w_status_nxt   = 1'b1;
                w_released_nxt = 1'b0;
            end else begin
                w_extended_nxt = 1'b0;
                w_released_nxt = 1'b0;
                if (r_released) begin
`ifdef PS2_KEY_RELEASE_EN
                    w_push         = 1'b1;
                    w_evt.released = 1'b1;
`endif
                end else begin
                    w_push = 1'b1;
                    if (!r_extended) begin
                        case (scan_code_byte)
                            c_SC_58: begin
                                w_caps_nxt   = !status_caps_lock;
                                w_status_nxt = 1'b1;
                            end
                            c_SC_77: begin
                                w_num_nxt    = !status_num_lock;
                                w_status_nxt = 1'b1;
                            end
                            c_SC_7E: begin
                                w_scroll_nxt = !status_scroll_lock;
                                w_status_nxt = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Register prefix flags, Pause counter, lock bits and one-cycle strobes
    always_ff @(posedge clk or negedge reset_low) begin
        if (!reset_low) begin
            r_extended         <= 1'b0;
            r_released         <= 1'b0;
            r_pause_cnt        <= 3'd0;
            acknowledge        <= 1'b0;
            resend             <= 1'b0;
            set_status         <= 1'b0;
            status_caps_lock   <= 1'b0;
            status_num_lock    <= 1'b0;
            status_scroll_lock <= 1'b0;
        end else begin
            r_extended         <= w_extended_nxt;
            r_released         <= w_released_nxt;
            r_pause_cnt        <= w_pause_cnt_nxt;
            acknowledge        <= w_ack_nxt;
            resend             <= w_resend_nxt;
            set_status         <= w_status_nxt;
            status_caps_lock   <= w_caps_nxt;
            status_num_lock    <= w_num_nxt;
            status_scroll_lock <= w_scroll_nxt;
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (evt_t)
    ) u_event_fifo (
        .clk       (clk),
        .rst_n     (reset_low),
        .in_valid  (w_push),
        .in_ready  (w_fifo_in_ready),
        .in_data   (w_evt),
        .out_valid (event_valid),
        .out_ready (event_ready),
        .out_data  (w_head)
    );

    assign event_code     = w_head.code;
    assign event_extended = w_head.extended;
`ifdef PS2_KEY_RELEASE_EN
    assign event_released = w_head.released;
`else
    assign event_released = 1'b0;
`endif

endmodule : ps2_key_decoder
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Directed self-checking bench for ps2_key_decoder (depth 4).
//               Expectations follow PS2_KEY_RELEASE_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       reset_low;
    logic       scan_code_valid;
    logic [7:0] scan_code_byte;
    logic       scan_code_ready;
    logic       event_valid;
    logic       event_ready;
    logic [7:0] event_code;
    logic       event_extended;
    logic       event_released;
    logic       acknowledge;
    logic       resend;
    logic       set_status;
    logic       status_caps_lock;
    logic       status_num_lock;
    logic       status_scroll_lock;

    int n_cmp = 0;
    int n_err = 0;

    // Monitor-side records: dequeued events {rel, ext, code} and strobe counts
    logic [9:0] ev_log[$];
    int         ack_cnt    = 0;
    int         resend_cnt = 0;
    int         status_cnt = 0;

    always #5 clk = ~clk;

    ps2_key_decoder #(.FIFO_DEPTH(4)) dut (
        .clk                (clk),
        .reset_low          (reset_low),
        .scan_code_valid    (scan_code_valid),
        .scan_code_byte     (scan_code_byte),
        .scan_code_ready    (scan_code_ready),
        .event_valid        (event_valid),
        .event_ready        (event_ready),
        .event_code         (event_code),
        .event_extended     (event_extended),
        .event_released     (event_released),
        .acknowledge        (acknowledge),
        .resend             (resend),
        .set_status         (set_status),
        .status_caps_lock   (status_caps_lock),
        .status_num_lock    (status_num_lock),
        .status_scroll_lock (status_scroll_lock)
    );

    // Record handshakes and strobes mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (reset_low) begin
            if (event_valid && event_ready)
                ev_log.push_back({event_released, event_extended, event_code});
            if (acknowledge) ack_cnt++;
            if (resend)      resend_cnt++;
            if (set_status)  status_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte and hold it until the decoder accepts it
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        scan_code_valid = 1'b1;
        scan_code_byte  = b;
        while (!scan_code_ready && t < 50) begin
            tick(1);
            t++;
        end
        n_cmp++;
        assert (t < 50) else begin
            n_err++;
            $error("FAIL send_timeout: byte %0h not accepted within %0d cycles", b, t);
        end
        tick(1);
        scan_code_valid = 1'b0;
    endtask

    task automatic expect_event(input string tag, input logic [9:0] exp);
        logic [9:0] got;
        got = (ev_log.size() > 0) ? ev_log.pop_front() : 10'h3FF;
        check(tag, 32'(got), 32'(exp));
    endtask

    task automatic pulse_reset();
        reset_low = 1'b0;
        tick(2);
        reset_low = 1'b1;
        tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int a0;
        int r0;
        reset_low       = 1'b0;
        scan_code_valid = 1'b0;
        scan_code_byte  = 8'h00;
        event_ready     = 1'b0;
        tick(3);

        // Reset state
        check("rst_event_valid", 32'(event_valid), 0);
        check("rst_scan_ready",  32'(scan_code_ready), 1);
        check("rst_event_code",  32'(event_code), 0);
        check("rst_event_ext",   32'(event_extended), 0);
        check("rst_event_rel",   32'(event_released), 0);
        check("rst_locks",       32'({status_caps_lock, status_num_lock, status_scroll_lock}), 0);
        check("rst_strobes",     32'({acknowledge, resend, set_status}), 0);
        reset_low = 1'b1;
        tick(1);

        // Plain and extended presses
        event_ready = 1'b1;
        send_byte(8'h1C);
        check("plain_ready", 32'(scan_code_ready), 1);
        send_byte(8'hE0);
        check("prefix_ready", 32'(scan_code_ready), 1);
        send_byte(8'h75);
        check("ext_ready", 32'(scan_code_ready), 1);
        tick(2);
        expect_event("ev_1C", {2'b00, 8'h1C});
        expect_event("ev_E0_75", {2'b01, 8'h75});

        // Caps Lock press and release
        s0 = status_cnt;
        send_byte(8'h58);
        check("caps_status_pulse", 32'(set_status), 1);
        check("caps_on", 32'(status_caps_lock), 1);
        tick(1);
        check("caps_status_low", 32'(set_status), 0);
        send_byte(8'hF0);
        send_byte(8'h58);
        tick(2);
        check("caps_after_release", 32'(status_caps_lock), 1);
        check("caps_status_count", 32'(status_cnt - s0), 1);
        expect_event("ev_58_press", {2'b00, 8'h58});
`ifdef PS2_KEY_RELEASE_EN
        expect_event("ev_58_release", {2'b10, 8'h58});
`endif
        check("caps_no_extra_events", 32'(ev_log.size()), 0);

        // Pause sequence yields one event and no lock toggle
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        tick(2);
        check("pause_num_untouched", 32'(status_num_lock), 0);
        check("pause_event_count", 32'(ev_log.size()), 1);
        expect_event("ev_pause", {2'b00, 8'hE1});
        send_byte(8'h77);
        check("num_status_pulse", 32'(set_status), 1);
        check("num_on", 32'(status_num_lock), 1);
        tick(2);
        expect_event("ev_77", {2'b00, 8'h77});

        // Back-pressure with a stalled consumer
        event_ready = 1'b0;
        send_byte(8'h1C); send_byte(8'h1B); send_byte(8'h23); send_byte(8'h2B);
        check("full_ready_low", 32'(scan_code_ready), 0);
        check("full_head", 32'(event_code), 32'h1C);
        scan_code_valid = 1'b1;
        scan_code_byte  = 8'h34;
        tick(3);
        check("stall_ready_low", 32'(scan_code_ready), 0);
        check("stall_head_stable", 32'(event_code), 32'h1C);
        event_ready = 1'b1;
        tick(1);
        event_ready = 1'b0;
        check("after_deq_ready", 32'(scan_code_ready), 1);
        check("after_deq_head", 32'(event_code), 32'h1B);
        tick(1);
        scan_code_valid = 1'b0;
        check("refill_ready_low", 32'(scan_code_ready), 0);
        event_ready = 1'b1;
        tick(6);
        expect_event("ord_1C", {2'b00, 8'h1C});
        expect_event("ord_1B", {2'b00, 8'h1B});
        expect_event("ord_23", {2'b00, 8'h23});
        expect_event("ord_2B", {2'b00, 8'h2B});
        expect_event("ord_34", {2'b00, 8'h34});
        check("drained_valid", 32'(event_valid), 0);

        // Command responses
        a0 = ack_cnt; r0 = resend_cnt; s0 = status_cnt;
        send_byte(8'hFA);
        send_byte(8'hFE);
        send_byte(8'hAA);
        tick(2);
        check("ack_count", 32'(ack_cnt - a0), 1);
        check("resend_count", 32'(resend_cnt - r0), 1);
        check("aa_status_count", 32'(status_cnt - s0), 1);
        check("resp_no_events", 32'(ev_log.size()), 0);

        // Reset mid-prefix
        send_byte(8'hE0);
        send_byte(8'hF0);
        pulse_reset();
        check("rst2_caps", 32'(status_caps_lock), 0);
        check("rst2_num", 32'(status_num_lock), 0);
        check("rst2_empty", 32'(event_valid), 0);
        send_byte(8'h1C);
        tick(2);
        expect_event("ev_after_prefix_rst", {2'b00, 8'h1C});

        // Reset mid-Pause
        send_byte(8'hE1);
        send_byte(8'h14);
        tick(2);
        expect_event("ev_pause2", {2'b00, 8'hE1});
        pulse_reset();
        send_byte(8'h1C);
        tick(2);
        expect_event("ev_after_pause_rst", {2'b00, 8'h1C});
        check("final_empty", 32'(event_valid), 0);
        check("final_log_empty", 32'(ev_log.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ps2_key_decoder
`default_nettype wire
